// File: rtl/lz77_pkg.sv
// Shared sizes and FSM encoding for the LZ77 encoder.
package lz77_pkg;
  localparam int unsigned SB_DEPTH = 9;
  localparam int unsigned LA_DEPTH = 8;
  localparam int unsigned DW       = 8;
  localparam int unsigned POS_W    = 4;
  localparam int unsigned LEN_W    = 3;
  localparam int unsigned CNT_W    = 4;

  typedef enum logic [2:0] {
    StFill,
    StSearch,
    StEmit,
    StShift,
    StDone
  } state_e;
endpackage

// File: rtl/lz77_match_len.sv
// Match length of the look-ahead against candidate position pos_i; the window
// runs from the search buffer into the look-ahead, so overlapping matches count.
module lz77_match_len
  import lz77_pkg::*;
(
  input  logic [DW-1:0]    sb_i [SB_DEPTH],
  input  logic [DW-1:0]    la_i [LA_DEPTH],
  input  logic [POS_W-1:0] pos_i,
  input  logic [LEN_W-1:0] cap_i,
  output logic [LEN_W-1:0] len_o
);

  always_comb begin
    logic             run;
    logic [DW-1:0]    c;
    logic [POS_W-1:0] sb_idx;
    logic [LEN_W-1:0] la_idx;
    len_o  = '0;
    run    = 1'b1;
    c      = '0;
    sb_idx = '0;
    la_idx = '0;
    for (int i = 0; i < LA_DEPTH - 1; i++) begin
      sb_idx = pos_i - POS_W'(i);
      la_idx = LEN_W'(i) - LEN_W'(pos_i) - LEN_W'(1);
      if (POS_W'(i) <= pos_i) c = sb_i[sb_idx];
      else                    c = la_i[la_idx];
      run = run && (LEN_W'(i) < cap_i) && (la_i[i] == c);
      if (run) len_o = len_o + LEN_W'(1);
    end
  end

endmodule

// File: rtl/lz77_encoder.sv
// LZ77 encoder: fills a look-ahead, serially searches a 9-entry window and
// emits one (pos, len, char) triplet per handshake.
module lz77_encoder
  import lz77_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             in_valid_i,
  input  logic [DW-1:0]    in_char_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [POS_W-1:0] code_pos_o,
  output logic [LEN_W-1:0] code_len_o,
  output logic [DW-1:0]    chardata_o,
  output logic             finish_o
);

  state_e           state_q, state_d;
  logic [DW-1:0]    sb_q [SB_DEPTH];
  logic [DW-1:0]    sb_d [SB_DEPTH];
  logic [DW-1:0]    la_q [LA_DEPTH];
  logic [DW-1:0]    la_d [LA_DEPTH];
  logic [CNT_W-1:0] sb_cnt_q, sb_cnt_d, la_cnt_q, la_cnt_d, shift_cnt_q, shift_cnt_d;
  logic             seen_last_q, seen_last_d;
  logic [POS_W-1:0] pos_q, pos_d, best_pos_q, best_pos_d, code_pos_q, code_pos_d;
  logic [LEN_W-1:0] best_len_q, best_len_d, code_len_q, code_len_d;
  logic [DW-1:0]    chardata_q, chardata_d;
  logic [LEN_W-1:0] cap, cand_len;

  // Cap keeps at least one look-ahead character for the literal.
  assign cap = (la_cnt_q >= CNT_W'(LA_DEPTH)) ? LEN_W'(LA_DEPTH - 1)
                                              : LEN_W'(la_cnt_q - CNT_W'(1));

  lz77_match_len u_match (
    .sb_i  (sb_q),
    .la_i  (la_q),
    .pos_i (pos_q),
    .cap_i (cap),
    .len_o (cand_len)
  );

  assign in_ready_o  = (state_q == StFill) && (la_cnt_q < CNT_W'(LA_DEPTH)) && !seen_last_q;
  assign out_valid_o = (state_q == StEmit);
  assign finish_o    = (state_q == StDone);
  assign code_pos_o  = code_pos_q;
  assign code_len_o  = code_len_q;
  assign chardata_o  = chardata_q;

  always_comb begin
    state_d     = state_q;
    sb_d        = sb_q;
    la_d        = la_q;
    sb_cnt_d    = sb_cnt_q;
    la_cnt_d    = la_cnt_q;
    shift_cnt_d = shift_cnt_q;
    seen_last_d = seen_last_q;
    pos_d       = pos_q;
    best_pos_d  = best_pos_q;
    best_len_d  = best_len_q;
    code_pos_d  = code_pos_q;
    code_len_d  = code_len_q;
    chardata_d  = chardata_q;
    case (state_q)
      StFill: begin
        if (in_valid_i && in_ready_o) begin
          la_d[la_cnt_q[LEN_W-1:0]] = in_char_i;
          la_cnt_d = la_cnt_q + CNT_W'(1);
          if (in_last_i) seen_last_d = 1'b1;
        end else if (la_cnt_q == CNT_W'(LA_DEPTH) || (seen_last_q && la_cnt_q != '0)) begin
          state_d    = StSearch;
          pos_d      = '0;
          best_pos_d = '0;
          best_len_d = '0;
        end else if (seen_last_q) begin
          state_d = StDone;
        end
      end
      StSearch: begin
        if (pos_q < sb_cnt_q && cand_len > best_len_q) begin
          best_pos_d = pos_q;
          best_len_d = cand_len;
        end
        if (pos_q == POS_W'(SB_DEPTH - 1)) begin
          state_d    = StEmit;
          code_pos_d = best_pos_d;
          code_len_d = best_len_d;
          chardata_d = la_q[best_len_d];
        end else begin
          pos_d = pos_q + POS_W'(1);
        end
      end
      StEmit: begin
        if (out_ready_i) begin
          state_d     = StShift;
          shift_cnt_d = CNT_W'(best_len_q) + CNT_W'(1);
        end
      end
      StShift: begin
        for (int k = SB_DEPTH - 1; k > 0; k--) sb_d[k] = sb_q[k-1];
        sb_d[0] = la_q[0];
        for (int k = 0; k < LA_DEPTH - 1; k++) la_d[k] = la_q[k+1];
        la_d[LA_DEPTH-1] = '0;
        la_cnt_d    = la_cnt_q - CNT_W'(1);
        shift_cnt_d = shift_cnt_q - CNT_W'(1);
        if (sb_cnt_q < CNT_W'(SB_DEPTH)) sb_cnt_d = sb_cnt_q + CNT_W'(1);
        if (shift_cnt_q == CNT_W'(1)) state_d = StFill;
      end
      StDone: ;
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= StFill;
      sb_q        <= '{default: '0};
      la_q        <= '{default: '0};
      sb_cnt_q    <= '0;
      la_cnt_q    <= '0;
      shift_cnt_q <= '0;
      seen_last_q <= 1'b0;
      pos_q       <= '0;
      best_pos_q  <= '0;
      best_len_q  <= '0;
      code_pos_q  <= '0;
      code_len_q  <= '0;
      chardata_q  <= '0;
    end else begin
      state_q     <= state_d;
      sb_q        <= sb_d;
      la_q        <= la_d;
      sb_cnt_q    <= sb_cnt_d;
      la_cnt_q    <= la_cnt_d;
      shift_cnt_q <= shift_cnt_d;
      seen_last_q <= seen_last_d;
      pos_q       <= pos_d;
      best_pos_q  <= best_pos_d;
      best_len_q  <= best_len_d;
      code_pos_q  <= code_pos_d;
      code_len_q  <= code_len_d;
      chardata_q  <= chardata_d;
    end
  end

endmodule

// File: tb/tb_lz77_encoder.sv
// Scoreboard bench for lz77_encoder: expected triplets are queued per stream
// and compared as the encoder hands them off.
module tb_lz77_encoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = '0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] code_pos;
  logic [2:0] code_len;
  logic [7:0] chardata;
  logic       finish;

  typedef struct packed {
    logic [3:0] pos;
    logic [2:0] len;
    logic [7:0] ch;
  } trip_t;

  trip_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    stall_left = 0;
  bit    held = 1'b0;
  trip_t snap;

  lz77_encoder dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .in_valid_i  (in_valid),
    .in_char_i   (in_char),
    .in_last_i   (in_last),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .code_pos_o  (code_pos),
    .code_len_o  (code_len),
    .chardata_o  (chardata),
    .finish_o    (finish)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Consumer: ready is changed on the falling edge so the next rising edge sees it.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (stall_left > 0) begin
          out_ready = 1'b0;
          if (!held) begin
            snap = {code_pos, code_len, chardata};
            held = 1'b1;
          end else begin
            check_eq("stall_hold", {code_pos, code_len, chardata}, snap);
          end
          stall_left--;
        end else begin
          if (held) begin
            check_eq("stall_hold", {code_pos, code_len, chardata}, snap);
            held = 1'b0;
          end
          out_ready = 1'b1;
          if (exp_q.size() == 0) begin
            check_eq("unexpected_out", 1, 0);
          end else begin
            trip_t t;
            t = exp_q.pop_front();
            check_eq("code_pos", code_pos, t.pos);
            check_eq("code_len", code_len, t.len);
            check_eq("chardata", chardata, t.ch);
          end
        end
      end else if (held) begin
        check_eq("stall_valid", out_valid, 1);
        held = 1'b0;
      end
    end
  end

  task automatic push(input logic [3:0] p, input logic [2:0] l, input logic [7:0] c);
    exp_q.push_back({p, l, c});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    stall_left = 0;
    held = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Entered on a falling edge; returns on the falling edge after acceptance.
  task automatic drive_char(input logic [7:0] c, input bit last);
    int t = 0;
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check_eq("in_ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) begin
      drive_char(s[i], i == s.len() - 1);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int t = 0;
    while (!finish && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check_eq("finish", finish, 1);
    check_eq("in_ready_done", in_ready, 0);
    check_eq("drained", exp_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_code_pos", code_pos, 0);
    check_eq("rst_code_len", code_len, 0);
    check_eq("rst_chardata", chardata, 0);
    check_eq("rst_finish", finish, 0);
    check_eq("rst_in_ready", in_ready, 1);

    // Literals only
    push(0, 0, 8'h41); push(0, 0, 8'h42); push(0, 0, 8'h43);
    send_str("ABC", 0);
    wait_done();

    // Match overlapping into the look-ahead
    do_reset();
    push(0, 0, 8'h41); push(0, 0, 8'h42); push(1, 4, 8'h58);
    send_str("ABABABX", 0);
    wait_done();

    // Length cap, tie to position 0, single-character tail
    do_reset();
    push(0, 0, 8'h41); push(0, 7, 8'h41); push(0, 0, 8'h41);
    send_str("AAAAAAAAAA", 0);
    wait_done();

    // Downstream stall on the first triplet
    do_reset();
    stall_left = 5;
    push(0, 0, 8'h41); push(0, 0, 8'h42); push(0, 0, 8'h43);
    send_str("ABC", 0);
    wait_done();
    check_eq("stall_consumed", stall_left, 0);

    // Reset in the middle of a search, then a fresh stream
    do_reset();
    send_str("ABABABX", 0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    push(0, 0, 8'h41); push(0, 0, 8'h42); push(0, 0, 8'h43);
    send_str("ABC", 0);
    wait_done();

    // Single character
    do_reset();
    push(0, 0, 8'h5a);
    send_str("Z", 0);
    wait_done();

    // Bursty input matches back-to-back result
    do_reset();
    push(0, 0, 8'h41); push(0, 0, 8'h42); push(1, 4, 8'h58);
    send_str("ABABABX", 2);
    wait_done();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
